// File: rtl/spi_resp_mem_pkg.sv
// Shared types and default sizing for the SPI read-back register file.
package spi_resp_mem_pkg;

    localparam int AW_DEF   = 8;
    localparam int DW_DEF   = 8;
    localparam int SYNC_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LOOKUP,
        DATA,
        DONE
    } state_e;

endpackage

// File: rtl/spi_resp_mem_if.sv
// Serial link plus local write / read-notification signals of spi_resp_mem.
interface spi_resp_mem_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          sck;
    logic          en;
    logic          mosi;
    logic          miso;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic          busy;

    modport master (
        output sck, en, mosi, wr_en, wr_addr, wr_data,
        input  miso, rd_valid, rd_addr, busy
    );

    modport slave (
        input  sck, en, mosi, wr_en, wr_addr, wr_data,
        output miso, rd_valid, rd_addr, busy
    );

endinterface

// File: rtl/spi_in_sync.sv
// Equal-depth synchroniser for {sck, en, mosi} with sck edge and en rise pulses.
module spi_in_sync
    import spi_resp_mem_pkg::*;
#(
    parameter int SYNC = SYNC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] raw_i,        // {sck, en, mosi}
    output logic       en_o,
    output logic       mosi_o,
    output logic       sck_rise_o,
    output logic       sck_fall_o,
    output logic       en_rise_o
);

    logic [SYNC-1:0][2:0] stage_q;
    logic                 sck_prev_q;
    logic                 en_prev_q;

    // NOTE: every sequential block uses <= so all stages sample the old value
    // of their predecessor on the same edge; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q    <= '0;
            sck_prev_q <= 1'b0;
            en_prev_q  <= 1'b0;
        end else begin
            stage_q    <= {stage_q[SYNC-2:0], raw_i};
            sck_prev_q <= stage_q[SYNC-1][2];
            en_prev_q  <= stage_q[SYNC-1][1];
        end
    end

    assign en_o       = stage_q[SYNC-1][1];
    assign mosi_o     = stage_q[SYNC-1][0];
    assign sck_rise_o =  stage_q[SYNC-1][2] & ~sck_prev_q;
    assign sck_fall_o = ~stage_q[SYNC-1][2] &  sck_prev_q;
    assign en_rise_o  =  stage_q[SYNC-1][1] & ~en_prev_q;

endmodule

// File: rtl/spi_resp_mem.sv
// SPI mode-0 responder: receives an address on mosi and returns mem[addr] on miso.
module spi_resp_mem
    import spi_resp_mem_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int SYNC = SYNC_DEF
) (
    input logic            clk,
    input logic            rst,
    spi_resp_mem_if.slave  bus
);

    localparam int             CW        = $clog2(((AW > DW) ? AW : DW) + 1);
    localparam logic [CW-1:0]  ADDR_LAST = CW'(AW - 1);
    localparam logic [CW-1:0]  DATA_LAST = CW'(DW - 1);

    logic en_s, mosi_s, sck_rise, sck_fall, en_rise;

    spi_in_sync #(.SYNC(SYNC)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .raw_i      ({bus.sck, bus.en, bus.mosi}),
        .en_o       (en_s),
        .mosi_o     (mosi_s),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .en_rise_o  (en_rise)
    );

    logic [DW-1:0] mem_q [2**AW];

    // NOTE: the register file has no reset; contents are only defined once written,
    // which keeps it mappable onto plain RAM/latch-free flop arrays.
    always_ff @(posedge clk) begin
        if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
    end

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] rd_addr_q;
    logic [DW-1:0] shift_q;
    logic          miso_q;
    logic          rd_valid_q;
    logic [DW-1:0] lookup_data;

    // A write landing in the lookup cycle wins over the stored value.
    assign lookup_data = (bus.wr_en && (bus.wr_addr == addr_q)) ? bus.wr_data : mem_q[addr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rd_addr_q  <= '0;
            shift_q    <= '0;
            miso_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (en_rise) begin
                        cnt_q   <= '0;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (!en_s) begin
                        miso_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (sck_rise) begin
                        addr_q <= {addr_q[AW-2:0], mosi_s};
                        cnt_q  <= cnt_q + CW'(1);
                        if (cnt_q == ADDR_LAST) state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!en_s) begin
                        miso_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        shift_q    <= lookup_data;
                        rd_addr_q  <= addr_q;
                        rd_valid_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (!en_s) begin
                        miso_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (sck_fall) begin
                        miso_q  <= shift_q[DW-1];
                        shift_q <= shift_q << 1;
                        cnt_q   <= cnt_q + CW'(1);
                        if (cnt_q == DATA_LAST) state_q <= DONE;
                    end
                end
                DONE: begin
                    // The last data bit is still being sampled on the next rise,
                    // so miso is parked at 0 only from the trailing fall onward.
                    if (sck_fall) miso_q <= 1'b0;
                    if (!en_s) begin
                        miso_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.miso     = miso_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_resp_mem.sv
// Directed bench for spi_resp_mem: acts as the SPI master, scoreboards returned bytes.
module tb_spi_resp_mem;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_resp_mem_if #(.AW(AW), .DW(DW)) bus ();

    spi_resp_mem #(.AW(AW), .DW(DW), .SYNC(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            checks    = 0;
    int            failures  = 0;
    int            rv_count  = 0;
    logic [AW-1:0] rv_addr   = '0;
    logic [DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            rv_count = rv_count + 1;
            rv_addr  = bus.rd_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // One sck period: set mosi, sample miso just before the rise, optionally hit the lookup cycle with a write.
    task automatic sck_cycle(input logic mo, input int hp, input bit wr_hit,
                             input logic [AW-1:0] wa, input logic [DW-1:0] wd, output logic got);
        bus.mosi = mo;
        repeat (hp) @(negedge clk);
        got     = bus.miso;
        bus.sck = 1'b1;
        if (wr_hit) begin
            repeat (SYNC + 1) @(negedge clk);
            bus.wr_en   = 1'b1;
            bus.wr_addr = wa;
            bus.wr_data = wd;
            @(negedge clk);
            bus.wr_en   = 1'b0;
            repeat (hp - SYNC - 2) @(negedge clk);
        end else begin
            repeat (hp) @(negedge clk);
        end
        bus.sck = 1'b0;
    endtask

    task automatic read_frame(input logic [AW-1:0] addr, input int hp, input int extra,
                              input bit collide, input logic [DW-1:0] wd);
        logic          b;
        logic [DW-1:0] got;
        logic [DW-1:0] exp;
        int            rv0;
        rv0    = rv_count;
        got    = '0;
        bus.en = 1'b1;
        repeat (hp) @(negedge clk);
        for (int i = 0; i < AW; i++) sck_cycle(addr[AW-1-i], hp, collide && (i == AW - 1), addr, wd, b);
        for (int i = 0; i < DW; i++) begin
            sck_cycle(1'b0, hp, 1'b0, '0, '0, b);
            got[DW-1-i] = b;
        end
        for (int k = 0; k < extra; k++) begin
            sck_cycle(1'b0, hp, 1'b0, '0, '0, b);
            check("overrun_miso", 32'(b), 32'(1'b0));
            check("overrun_busy", 32'(bus.busy), 32'(1'b1));
        end
        repeat (hp) @(negedge clk);
        bus.en = 1'b0;
        repeat (SYNC + 6) @(negedge clk);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check("read_data", 32'(got), 32'(exp));
        end
        check("rd_valid_count", 32'(rv_count - rv0), 32'd1);
        check("rd_addr_at_valid", 32'(rv_addr), 32'(addr));
        check("rd_addr_hold", 32'(bus.rd_addr), 32'(addr));
        check("idle_after_frame", 32'(bus.busy), 32'(1'b0));
    endtask

    initial begin
        logic b;
        int   rv0;
        bus.sck     = 1'b0;
        bus.en      = 1'b0;
        bus.mosi    = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // Reset state
        repeat (5) @(negedge clk);
        check("reset_miso", 32'(bus.miso), 32'(1'b0));
        check("reset_rd_valid", 32'(bus.rd_valid), 32'(1'b0));
        check("reset_rd_addr", 32'(bus.rd_addr), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'(1'b0));
        rst = 1'b0;

        write_mem(8'h00, 8'hA5);
        write_mem(8'h3C, 8'h81);
        write_mem(8'hFF, 8'h7E);
        write_mem(8'h10, 8'h5A);
        repeat (4) @(negedge clk);

        // Basic read at the slow sck rate
        exp_q.push_back(8'hA5);
        read_frame(8'h00, 50, 0, 1'b0, '0);

        // Back-to-back addressing
        exp_q.push_back(8'h81);
        read_frame(8'h3C, 6, 0, 1'b0, '0);
        exp_q.push_back(8'h7E);
        read_frame(8'hFF, 6, 0, 1'b0, '0);

        // Abort after 5 address bits
        rv0    = rv_count;
        bus.en = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) sck_cycle(1'b0, 6, 1'b0, '0, '0, b);
        repeat (4) @(negedge clk);
        bus.en = 1'b0;
        for (int k = 0; k < SYNC + 1; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) break;
        end
        check("abort_busy", 32'(bus.busy), 32'(1'b0));
        check("abort_miso", 32'(bus.miso), 32'(1'b0));
        repeat (20) @(negedge clk);
        check("abort_no_rd_valid", 32'(rv_count - rv0), 32'd0);
        check("abort_rd_addr_kept", 32'(bus.rd_addr), 32'hFF);
        exp_q.push_back(8'hA5);
        read_frame(8'h00, 6, 0, 1'b0, '0);

        // Overrun: extra sck cycles after the data byte
        exp_q.push_back(8'h81);
        read_frame(8'h3C, 6, 4, 1'b0, '0);

        // Write collision in the lookup cycle
        exp_q.push_back(8'hC3);
        read_frame(8'h10, 6, 0, 1'b1, 8'hC3);

        // Reset in the middle of the data phase
        bus.en = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < AW; i++) sck_cycle(AW'(8'h3C) >> (AW - 1 - i) & 1'b1, 6, 1'b0, '0, '0, b);
        for (int i = 0; i < 3; i++) sck_cycle(1'b0, 6, 1'b0, '0, '0, b);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_miso", 32'(bus.miso), 32'(1'b0));
        check("midrst_rd_valid", 32'(bus.rd_valid), 32'(1'b0));
        check("midrst_rd_addr", 32'(bus.rd_addr), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'(1'b0));
        bus.en = 1'b0;
        repeat (20) @(negedge clk);
        exp_q.push_back(8'h81);
        read_frame(8'h3C, 6, 0, 1'b0, '0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
